// File: rtl/tow_playfield.sv
// Tug of War playfield: moves one lit LED on player presses,
// awards round points, keeps saturating scores and a match-over state.
module tow_playfield #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  l_press,
  input  logic                  r_press,
  input  logic                  new_round,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [1:0]            winner,
  output logic [SCORE_W-1:0]    l_score,
  output logic [SCORE_W-1:0]    r_score,
  output logic                  game_over
);

  localparam int CENTER = (NUM_LIGHTS - 1) / 2;
  localparam int POS_W  = $clog2(NUM_LIGHTS);

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_LIGHTS - 1);
  localparam logic [POS_W-1:0] POS_CTR = POS_W'(CENTER);
  localparam logic [POS_W-1:0] POS_MIN = '0;

  localparam logic [NUM_LIGHTS-1:0] LIGHT_ONE =
    {{(NUM_LIGHTS-1){1'b0}}, 1'b1};
  localparam logic [NUM_LIGHTS-1:0] LIGHT_CTR =
    LIGHT_ONE << CENTER;

  localparam logic [SCORE_W-1:0] MAX_SCORE = '1;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_RIGHT = 2'b01;
  localparam logic [1:0] WIN_LEFT  = 2'b10;

  typedef enum logic [1:0] {
    S_PLAY,
    S_POINT,
    S_MATCH_OVER
  } state_t;

  state_t                  r_state;
  logic [POS_W-1:0]        r_pos;
  logic [NUM_LIGHTS-1:0]   r_lights;
  logic [1:0]              r_winner;
  logic [SCORE_W-1:0]      r_l_score;
  logic [SCORE_W-1:0]      r_r_score;
  logic                    r_game_over;

  logic                    w_l_move;
  logic                    w_r_move;
  logic [SCORE_W-1:0]      w_l_inc;
  logic [SCORE_W-1:0]      w_r_inc;

  always_comb begin
    w_l_move = l_press & ~r_press;
    w_r_move = r_press & ~l_press;
    w_l_inc  = r_l_score + 1'b1;
    w_r_inc  = r_r_score + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_PLAY;
      r_pos       <= POS_CTR;
      r_lights    <= LIGHT_CTR;
      r_winner    <= WIN_NONE;
      r_l_score   <= '0;
      r_r_score   <= '0;
      r_game_over <= 1'b0;
    end else begin
      unique case (r_state)
        S_PLAY: begin
          if (w_l_move) begin
            if (r_pos == POS_MAX) begin
              r_lights <= '0;
              r_winner <= WIN_LEFT;
              if (r_l_score != MAX_SCORE) begin
                r_l_score <= w_l_inc;
              end
              // Reaching the cap ends the match on this same edge.
              if (w_l_inc == MAX_SCORE) begin
                r_state     <= S_MATCH_OVER;
                r_game_over <= 1'b1;
              end else begin
                r_state <= S_POINT;
              end
            end else begin
              r_pos    <= r_pos + 1'b1;
              r_lights <= r_lights << 1;
            end
          end else if (w_r_move) begin
            if (r_pos == POS_MIN) begin
              r_lights <= '0;
              r_winner <= WIN_RIGHT;
              if (r_r_score != MAX_SCORE) begin
                r_r_score <= w_r_inc;
              end
              if (w_r_inc == MAX_SCORE) begin
                r_state     <= S_MATCH_OVER;
                r_game_over <= 1'b1;
              end else begin
                r_state <= S_POINT;
              end
            end else begin
              r_pos    <= r_pos - 1'b1;
              r_lights <= r_lights >> 1;
            end
          end
        end
        S_POINT: begin
          if (new_round) begin
            r_state  <= S_PLAY;
            r_pos    <= POS_CTR;
            r_lights <= LIGHT_CTR;
            r_winner <= WIN_NONE;
          end
        end
        S_MATCH_OVER: begin
          r_lights <= '0;
        end
        default: begin
          r_state  <= S_PLAY;
          r_pos    <= POS_CTR;
          r_lights <= LIGHT_CTR;
          r_winner <= WIN_NONE;
        end
      endcase
    end
  end

  assign lights    = r_lights;
  assign winner    = r_winner;
  assign l_score   = r_l_score;
  assign r_score   = r_r_score;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_tow_playfield.sv
// Directed bench for tow_playfield with NUM_LIGHTS=9, SCORE_W=3.
// Expected values are hand-computed constants.
module tb_tow_playfield;

  logic       clk;
  logic       reset;
  logic       l_press;
  logic       r_press;
  logic       new_round;
  logic [8:0] lights;
  logic [1:0] winner;
  logic [2:0] l_score;
  logic [2:0] r_score;
  logic       game_over;

  int total;
  int bad;

  tow_playfield #(
    .NUM_LIGHTS(9),
    .SCORE_W   (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .l_press  (l_press),
    .r_press  (r_press),
    .new_round(new_round),
    .lights   (lights),
    .winner   (winner),
    .l_score  (l_score),
    .r_score  (r_score),
    .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic l, input logic r, input logic n);
    @(negedge clk);
    l_press   = l;
    r_press   = r;
    new_round = n;
    @(posedge clk);
    #1;
    l_press   = 1'b0;
    r_press   = 1'b0;
    new_round = 1'b0;
  endtask

  task automatic chk_all(input string tag,
                         input logic [8:0] e_lights,
                         input logic [1:0] e_win,
                         input logic [2:0] e_ls,
                         input logic [2:0] e_rs,
                         input logic       e_go);
    chk({tag, ".lights"}, 32'(lights), 32'(e_lights));
    chk({tag, ".winner"}, 32'(winner), 32'(e_win));
    chk({tag, ".l_score"}, 32'(l_score), 32'(e_ls));
    chk({tag, ".r_score"}, 32'(r_score), 32'(e_rs));
    chk({tag, ".game_over"}, 32'(game_over), 32'(e_go));
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    l_press   = 1'b0;
    r_press   = 1'b0;
    new_round = 1'b0;

    // Asynchronous reset before the first clock edge
    #3 reset = 1'b0;
    #1;
    chk_all("rst_async", 9'h010, 2'b00, 3'd0, 3'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_all("rst_hold", 9'h010, 2'b00, 3'd0, 3'd0, 1'b0);

    // Left walks to the edge and scores
    step(1, 0, 0); chk("l1", 32'(lights), 32'h020);
    step(1, 0, 0); chk("l2", 32'(lights), 32'h040);
    step(1, 0, 0); chk("l3", 32'(lights), 32'h080);
    step(1, 0, 0); chk("l4", 32'(lights), 32'h100);
    step(1, 0, 0);
    chk_all("lpoint", 9'h000, 2'b10, 3'd1, 3'd0, 1'b0);
    step(1, 0, 0);
    chk_all("point_lign", 9'h000, 2'b10, 3'd1, 3'd0, 1'b0);
    step(0, 1, 0);
    chk_all("point_rign", 9'h000, 2'b10, 3'd1, 3'd0, 1'b0);

    // new_round beats a same-cycle press
    step(0, 1, 1);
    chk_all("newrnd", 9'h010, 2'b00, 3'd1, 3'd0, 1'b0);
    step(0, 0, 1);
    chk_all("newrnd_play", 9'h010, 2'b00, 3'd1, 3'd0, 1'b0);

    // Simultaneous presses hold, single presses move
    step(1, 1, 0); chk("both", 32'(lights), 32'h010);
    step(0, 1, 0); chk("r_one", 32'(lights), 32'h008);
    step(1, 0, 0); chk("l_back", 32'(lights), 32'h010);

    // Second left point, then mid-round async reset
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    chk_all("lpoint2", 9'h000, 2'b10, 3'd2, 3'd0, 1'b0);
    step(0, 0, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    chk_all("pre_rst", 9'h080, 2'b00, 3'd2, 3'd0, 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk_all("rst_mid", 9'h010, 2'b00, 3'd0, 3'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step(1, 0, 0);
    chk_all("post_rst", 9'h020, 2'b00, 3'd0, 3'd0, 1'b0);
    step(0, 1, 0);
    chk("post_rst_r", 32'(lights), 32'h010);

    // Right wins seven rounds
    step(0, 1, 0); chk("r1", 32'(lights), 32'h008);
    step(0, 1, 0); chk("r2", 32'(lights), 32'h004);
    step(0, 1, 0); chk("r3", 32'(lights), 32'h002);
    step(0, 1, 0); chk("r4", 32'(lights), 32'h001);
    step(0, 1, 0);
    chk_all("rpoint1", 9'h000, 2'b01, 3'd0, 3'd1, 1'b0);
    step(0, 0, 1);
    for (int rnd = 2; rnd <= 6; rnd++) begin
      for (int i = 0; i < 5; i++) step(0, 1, 0);
      chk("rscore", 32'(r_score), 32'(rnd));
      chk("rnd_go", 32'(game_over), 32'h0);
      step(0, 0, 1);
      chk("rnd_ctr", 32'(lights), 32'h010);
    end
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    chk_all("match", 9'h000, 2'b01, 3'd0, 3'd7, 1'b1);
    step(0, 0, 1);
    chk_all("mo_newrnd", 9'h000, 2'b01, 3'd0, 3'd7, 1'b1);
    step(1, 0, 0);
    chk_all("mo_l", 9'h000, 2'b01, 3'd0, 3'd7, 1'b1);
    step(0, 1, 0);
    chk_all("mo_r", 9'h000, 2'b01, 3'd0, 3'd7, 1'b1);

    // Reset exits match-over
    #2 reset = 1'b0;
    #1;
    chk_all("mo_rst", 9'h010, 2'b00, 3'd0, 3'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
